led_blink_stretcher: RTL and testbench

Output-side counterpart of the switch debouncer. It converts single-cycle logic events (e.g. debounced transition strobes, bus activity) into human-visible LED blinks with guaranteed minimum on and off times. Up to a bounded number of events are queued so that N events produce N distinct blinks. It sits between core logic and a board LED pin.

---
 rtl/led_blink_stretcher.sv | 107 ++++++++++
 tb/tb_led_blink_stretcher.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/led_blink_stretcher.sv
// LED blink stretcher: turns single-cycle event strobes into visible blinks
// with guaranteed minimum on/off times. Events that arrive while a blink is
// in progress are counted (up to 2^CNT_W-1) and replayed back-to-back.
module led_blink_stretcher #(
  parameter int ON_TICKS        = 131072,
  parameter int OFF_TICKS       = 131072,
  parameter int CNT_W           = 4,
  parameter int LED_ACTIVE_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             event_in,
  input  logic             clear,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam logic [TW-1:0]    ON_LAST   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]    OFF_LAST  = TW'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;
  localparam logic             LED_LIT   = (LED_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             led_q, led_d;

  logic ev, on_done, off_done, direct, consume, accept;

  // A cleared cycle's event is ignored entirely; a clear on the last OFF
  // cycle also suppresses replay of the (now flushed) backlog.
  assign ev       = event_in & ~clear;
  assign on_done  = (state_q == S_ON)  && (timer_q == ON_LAST);
  assign off_done = (state_q == S_OFF) && (timer_q == OFF_LAST);
  assign consume  = off_done & ~clear & (pend_q != '0);
  assign direct   = ev & ((state_q == S_IDLE) | (off_done & (pend_q == '0)));
  assign accept   = ev & ~direct;

  // State and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: ON for ON_TICKS, OFF for OFF_TICKS, chain straight into the
  // next blink when there is work; timer restarts on every state entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ev) state_d = S_ON;
      S_ON:    if (on_done) state_d = S_OFF;
      S_OFF:   if (off_done) state_d = (consume | direct) ? S_ON : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    timer_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : timer_q + 1'b1;
  end

  // Pending counter: +accept -consume, saturating with a dropped-event pulse
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (clear) begin
      pend_d = '0;
    end else if (accept && !consume) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (consume && !accept) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Output decode: LED follows the next state so the pin is registered
  always_comb begin
    led_d = (state_d == S_ON) ? LED_LIT : ~LED_LIT;
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      led_q  <= ~LED_LIT;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      led_q  <= led_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign led      = led_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led_blink_stretcher.sv
// Scoreboarded random/directed bench for led_blink_stretcher (ON=4, OFF=3,
// CNT_W=2). The model tracks the elapsed time of the current blink and the
// number of waiting events; the monitor checks DUT outputs every cycle.
module tb_led_blink_stretcher;
  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int CW   = 2;
  localparam int PMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          led;
    logic          busy;
    logic [CW-1:0] pend;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          event_in = 1'b0;
  logic          clear = 1'b0;
  logic          led, busy, overflow;
  logic [CW-1:0] pending;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  // model state
  bit m_act = 0;
  int m_el  = 0;
  int m_pend = 0;
  bit m_ovf = 0;

  led_blink_stretcher #(.ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(CW), .LED_ACTIVE_HIGH(1)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .clear(clear),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per clock edge after stimulus
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{led: led, busy: busy, pend: pending, ovf: overflow};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b",
                   $time, a.led, a.busy, a.pend, a.ovf, e.led, e.busy, e.pend, e.ovf);
        end
      end
    end
  end

  // One cycle of stimulus plus reference-model update
  task automatic step(input logic e, input logic c);
    bit evv, last, direct, cons, acc;
    exp_t x;
    @(negedge clk);
    event_in = e;
    clear    = c;
    evv    = e && !c;
    last   = m_act && (m_el == ON + OFF - 1);
    direct = evv && (!m_act || (last && m_pend == 0));
    cons   = last && !c && (m_pend > 0);
    acc    = evv && !direct;
    m_ovf  = 0;
    if (c) m_pend = 0;
    else if (acc && !cons && m_pend == PMAX) m_ovf = 1;
    else m_pend = m_pend + int'(acc) - int'(cons);
    if (!m_act) begin
      if (evv) begin m_act = 1; m_el = 0; end
    end else if (last) begin
      if (direct || cons) m_el = 0;
      else m_act = 0;
    end else begin
      m_el++;
    end
    x.led  = m_act && (m_el < ON);
    x.busy = m_act;
    x.pend = CW'(m_pend);
    x.ovf  = m_ovf;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    total++;
    if (led !== 1'b0 || busy !== 1'b0 || pending !== '0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL %s got led=%b busy=%b pend=%0d ovf=%b want all 0", nm, led, busy, pending, overflow);
    end
  endtask

  initial begin
    int pct;
    #3;
    chk_zero("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single event
    step(1, 0); idle(12);
    // three back-to-back events
    step(1, 0); step(1, 0); step(1, 0); idle(25);
    // saturation: five events in a row
    repeat (5) step(1, 0);
    idle(32);
    // event on the last OFF cycle chains with no idle gap
    step(1, 0); idle(6); step(1, 0); idle(12);
    // clear together with an event flushes the backlog
    step(1, 0); step(1, 0); step(1, 0); step(1, 1); idle(12);

    // asynchronous reset in the middle of a blink
    step(1, 0); step(0, 0);
    @(negedge clk);
    event_in = 0; clear = 0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    m_act = 0; m_el = 0; m_pend = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 0); idle(10);

    // random traffic with varying density
    for (int blk = 0; blk < 30; blk++) begin
      pct = $urandom_range(5, 90);
      for (int i = 0; i < 80; i++)
        step(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
    idle(40);

    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
